// File: rtl/regfile_mp.sv
`timescale 1ns/1ps
// regfile_mp: multi-read-port register file with two write ports.
// r0 reads as zero. An optional scoreboard tracks pending registers.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   r_en[NRD]           per-port read enable
//   r_rn[NRD*ADDR_W]    per-port read register number
//   r_data[NRD*DATA_W]  per-port registered read data (1-cycle latency)
//   r_busy[NRD]         per-port registered pending flag
//   w0_*/w1_*           write ports (w1 wins on same register)
//   sb_set_en/sb_set_rn mark a register pending
//
// Macro REGFILE_MP_SCOREBOARD_EN enables the pending-bit scoreboard;
// without it r_busy is constant 0 and sb_set_* are ignored.

module regfile_mp #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 6,
    parameter int NRD    = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NRD-1:0]           r_en,
    input  logic [NRD*ADDR_W-1:0]    r_rn,
    output logic [NRD*DATA_W-1:0]    r_data,
    output logic [NRD-1:0]           r_busy,
    input  logic                     w0_en,
    input  logic [ADDR_W-1:0]        w0_rn,
    input  logic [DATA_W-1:0]        w0_data,
    input  logic                     w1_en,
    input  logic [ADDR_W-1:0]        w1_rn,
    input  logic [DATA_W-1:0]        w1_data,
    input  logic                     sb_set_en,
    input  logic [ADDR_W-1:0]        sb_set_rn
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];

    // Read value as it will be after this edge: w1 beats w0 beats storage.
    function automatic logic [DATA_W-1:0] rd_val(
        input logic [ADDR_W-1:0] rn
    );
        if (rn == '0)
            return '0;
        if (w1_en && w1_rn == rn)
            return w1_data;
        if (w0_en && w0_rn == rn)
            return w0_data;
        return regs[rn];
    endfunction

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else begin
            if (w0_en && w0_rn != '0)
                regs[w0_rn] <= w0_data;
            if (w1_en && w1_rn != '0)
                regs[w1_rn] <= w1_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else begin
            for (int k = 0; k < NRD; k++)
                if (r_en[k])
                    r_data[k*DATA_W +: DATA_W] <=
                        rd_val(r_rn[k*ADDR_W +: ADDR_W]);
        end
    end

`ifdef REGFILE_MP_SCOREBOARD_EN
    logic [DEPTH-1:0] pend;

    // Pending bit after this edge; a set overrides a same-cycle clear.
    function automatic logic pend_nxt(
        input logic [ADDR_W-1:0] rn
    );
        logic hit_set;
        logic hit_clr;
        hit_set = sb_set_en && sb_set_rn == rn;
        hit_clr = (w0_en && w0_rn == rn) ||
                  (w1_en && w1_rn == rn);
        return (rn != '0) && (hit_set || (pend[rn] && !hit_clr));
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                pend[i] <= pend_nxt(ADDR_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            for (int k = 0; k < NRD; k++)
                if (r_en[k])
                    r_busy[k] <= pend_nxt(r_rn[k*ADDR_W +: ADDR_W]);
        end
    end
`else
    logic unused_sb;
    assign unused_sb = ^{sb_set_en, sb_set_rn};
    assign r_busy    = '0;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
`timescale 1ns/1ps
// tb_regfile_mp: directed vectors against an array-based model,
// with per-cycle comparison plus literal spot checks.

module tb_regfile_mp;

    localparam int DW  = 64;
    localparam int AW  = 6;
    localparam int NRD = 3;
`ifdef REGFILE_MP_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [NRD-1:0]    r_en = '0;
    logic [NRD*AW-1:0] r_rn = '0;
    logic [NRD*DW-1:0] r_data;
    logic [NRD-1:0]    r_busy;
    logic          w0_en = 1'b0;
    logic [AW-1:0] w0_rn = '0;
    logic [DW-1:0] w0_data = '0;
    logic          w1_en = 1'b0;
    logic [AW-1:0] w1_rn = '0;
    logic [DW-1:0] w1_data = '0;
    logic          sb_set_en = 1'b0;
    logic [AW-1:0] sb_set_rn = '0;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] mem [64];
    bit            pend [64];
    logic [DW-1:0] exp_d [NRD];
    bit            exp_b [NRD];

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .r_en      (r_en),
        .r_rn      (r_rn),
        .r_data    (r_data),
        .r_busy    (r_busy),
        .w0_en     (w0_en),
        .w0_rn     (w0_rn),
        .w0_data   (w0_data),
        .w1_en     (w1_en),
        .w1_rn     (w1_rn),
        .w1_data   (w1_data),
        .sb_set_en (sb_set_en),
        .sb_set_rn (sb_set_rn)
    );

    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) begin
            mem[i]  = '0;
            pend[i] = 1'b0;
        end
        for (int k = 0; k < NRD; k++) begin
            exp_d[k] = '0;
            exp_b[k] = 1'b0;
        end
    endtask

    // Model: apply the edge's updates to state first, then reads
    // observe the updated state.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_clear();
        end else begin
            if (w0_en) pend[w0_rn] = 1'b0;
            if (w1_en) pend[w1_rn] = 1'b0;
            if (sb_set_en) pend[sb_set_rn] = 1'b1;
            pend[0] = 1'b0;
            if (w0_en) mem[w0_rn] = w0_data;
            if (w1_en) mem[w1_rn] = w1_data;
            mem[0] = '0;
            for (int k = 0; k < NRD; k++)
                if (r_en[k]) begin
                    exp_d[k] = mem[r_rn[k*AW +: AW]];
                    exp_b[k] = SB && pend[r_rn[k*AW +: AW]];
                end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < NRD; k++) begin
            check($sformatf("cyc_p%0d_data", k),
                  r_data[k*DW +: DW], exp_d[k]);
            check($sformatf("cyc_p%0d_busy", k),
                  DW'(r_busy[k]), DW'(exp_b[k]));
        end
    end

    task automatic lit(input string name, input int k,
                       input logic [DW-1:0] d, input bit b);
        check({name, "_data"}, r_data[k*DW +: DW], d);
        check({name, "_busy"}, DW'(r_busy[k]), DW'(b));
    endtask

    task automatic rd(input int k, input int rn);
        r_en[k] = 1'b1;
        r_rn[k*AW +: AW] = AW'(rn);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        r_en = '0;
        w0_en = 1'b0;
        w1_en = 1'b0;
        sb_set_en = 1'b0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NRD; k++) lit("in_reset", k, '0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // read r5 on all ports after reset
        for (int k = 0; k < NRD; k++) rd(k, 5);
        tick();
        for (int k = 0; k < NRD; k++) lit("r5_post_reset", k, '0, 1'b0);

        // dual write same register, w1 wins, forwarded to a read
        w0_en = 1; w0_rn = 7; w0_data = 64'h1111;
        w1_en = 1; w1_rn = 7; w1_data = 64'h2222;
        rd(0, 7);
        tick();
        lit("r7_fwd", 0, 64'h2222, 1'b0);
        rd(1, 7); rd(2, 7);
        tick();
        lit("r7_p1", 1, 64'h2222, 1'b0);
        lit("r7_p2", 2, 64'h2222, 1'b0);

        // register 0 stays zero and never busy
        w0_en = 1; w0_rn = 0; w0_data = 64'hDEAD;
        sb_set_en = 1; sb_set_rn = 0;
        rd(0, 0);
        tick();
        lit("r0_fwd", 0, '0, 1'b0);
        rd(0, 0);
        tick();
        lit("r0_later", 0, '0, 1'b0);

        // hold behaviour while r_en is low
        w1_en = 1; w1_rn = 3; w1_data = 64'hA5;
        tick();
        rd(0, 3);
        tick();
        lit("r3_a5", 0, 64'hA5, 1'b0);
        w0_en = 1; w0_rn = 3; w0_data = 64'h5A;
        tick();
        lit("r3_hold1", 0, 64'hA5, 1'b0);
        tick();
        lit("r3_hold2", 0, 64'hA5, 1'b0);
        rd(0, 3);
        tick();
        lit("r3_5a", 0, 64'h5A, 1'b0);

        // w0-only forwarding
        w0_en = 1; w0_rn = 10; w0_data = 64'h77;
        rd(2, 10);
        tick();
        lit("r10_fwd_w0", 2, 64'h77, 1'b0);

        // scoreboard behaviour
        sb_set_en = 1; sb_set_rn = 9;
        rd(2, 9);
        tick();
        lit("r9_set_same", 2, '0, SB);
        rd(0, 9);
        tick();
        lit("r9_set", 0, '0, SB);
        w0_en = 1; w0_rn = 9; w0_data = 64'h99;
        sb_set_en = 1; sb_set_rn = 9;
        rd(1, 9);
        tick();
        lit("r9_set_wins", 1, 64'h99, SB);
        w1_en = 1; w1_rn = 9; w1_data = 64'h42;
        tick();
        rd(0, 9);
        tick();
        lit("r9_cleared", 0, 64'h42, 1'b0);

        // mixed directed vectors checked by the model
        for (int i = 0; i < 24; i++) begin
            w0_en = (i % 3) != 0;
            w0_rn = AW'(i * 5);
            w0_data = 64'h1000 + 64'(i);
            w1_en = (i % 4) == 1;
            w1_rn = AW'(i * 3);
            w1_data = 64'hF000_0000_0000_0000 | 64'(i);
            sb_set_en = (i % 2) == 0;
            sb_set_rn = AW'(i * 7);
            if (i % 5 != 4) rd(0, i * 5);
            rd(1, i * 7);
            if (i % 2 == 1) rd(2, i * 3);
            tick();
        end

        // reset mid-stream discards state
        w0_en = 1; w0_rn = 12; w0_data = 64'hFF;
        sb_set_en = 1; sb_set_rn = 12;
        tick();
        rd(0, 12); rd(1, 12);
        tick();
        lit("r12_before", 0, 64'hFF, SB);
        w1_en = 1; w1_rn = 12; w1_data = 64'h33;
        rd(2, 12);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NRD; k++) lit("mid_reset", k, '0, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < NRD; k++) rd(k, 12);
        tick();
        for (int k = 0; k < NRD; k++) lit("r12_after", k, '0, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 64, register width in bits.
REQ-002 Parameter ADDR_W, default 6, register-number width; depth is 2^ADDR_W, with register 0 hardwired to zero.
REQ-003 Parameter NRD, default 3, number of read ports (1..8).
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 r_en  input  NRD  per-port read enable.
REQ-007 r_rn  input  NRD*ADDR_W  per-port read register number, port k at bits [k*ADDR_W +: ADDR_W].
REQ-008 r_data  output  NRD*DATA_W  per-port registered read data, port k at bits [k*DATA_W +: DATA_W].
REQ-009 r_busy  output  NRD  per-port registered scoreboard-pending flag.
REQ-010 w0_en, w1_en  input  1 each  write-port enables.
REQ-011 w0_rn, w1_rn  input  ADDR_W each  write register numbers.
REQ-012 w0_data, w1_data  input  DATA_W each  write data.
REQ-013 sb_set_en  input  1  mark a register pending (producer issued).
REQ-014 sb_set_rn  input  ADDR_W  register to mark pending.

Function
REQ-015 A write with wN_en=1 and wN_rn!=0 shall update the register at the clock edge; writes to register 0 shall be discarded.
REQ-016 If both ports write the same non-zero register in one cycle, the w1 data shall be stored.
REQ-017 Read latency shall be one cycle: r_data for port k reflects r_rn at the edge where r_en[k]=1.
REQ-018 Read-during-write: a read sampled in the same cycle as a matching write shall return the write data, with w1 winning over w0 as in REQ-016.
REQ-019 A read of register 0 shall return all zeros and r_busy=0 regardless of writes or scoreboard.
REQ-020 When r_en[k]=0, r_data and r_busy for port k shall hold their previous values; later writes do not update held data.
REQ-021 The scoreboard shall hold one pending bit per register 1..2^ADDR_W-1.
REQ-022 sb_set_en=1 with sb_set_rn!=0 shall set that register's pending bit at the edge.
REQ-023 Any write (w0 or w1) to a register shall clear its pending bit at the edge.
REQ-024 Simultaneous set and write-clear of the same register shall leave the bit set.
REQ-025 r_busy[k] shall capture, with r_data, the pending bit as it will be after the same edge (set/clear in that cycle included).
REQ-026 Multiple read ports addressing the same register shall return identical data and busy.

Reset
REQ-027 While rst_n=0: all registers, all pending bits, r_data and r_busy shall be 0, independent of clk.
REQ-028 Writes, sets and reads presented in the cycle rst_n deasserts shall take effect at the first rising edge after deassertion; assertion mid-operation discards all in-flight state.

Configuration
REQ-029 Macro REGFILE_MP_SCOREBOARD_EN: when defined, REQ-021..REQ-025 apply; when undefined, no scoreboard storage exists, sb_set_en/sb_set_rn are ignored, and r_busy shall be constant 0.

Verification
REQ-030 Reset, then read r5 on all ports -> r_data all 0, r_busy 0.
REQ-031 w0 writes r7=0x1111, w1 writes r7=0x2222 same cycle, port 0 reads r7 same cycle -> next cycle r_data0=0x2222; later read of r7 -> 0x2222.
REQ-032 Write r0=0xDEAD, read r0 -> 0; sb_set r0 -> r_busy 0.
REQ-033 Read r3 (=0xA5), drop r_en[0], write r3=0x5A -> r_data0 holds 0xA5 until r_en[0] reasserted, then 0x5A.
REQ-034 (SCOREBOARD_EN) sb_set r9, read r9 next cycle -> r_busy=1; w0 writes r9 while sb_set r9 and port 1 reads r9 -> r_busy1=1; w1 writes r9 alone -> subsequent read r_busy=0.
REQ-035 Assert rst_n mid-stream after writing r12=0xFF and setting r12 pending -> r_data, r_busy go 0 immediately; post-reset read r12 -> 0, busy 0.
